level_controller: RTL and testbench

Game-progression stage that owns the current level and drives the two-digit level counter on the 7-segment display. It sits between the round logic (which reports each round's win/fail) and the `seven_segments` display module. `o_Level` connects directly to the display's `counter` input, and `o_Blank` gates the segment outputs. The block sequences start, level-up pause, game-over blink and final-win hold, and tracks the best level reached since reset.

---
 rtl/level_controller_pkg.sv | 24 ++
 rtl/level_controller_tick_timer.sv | 35 +++
 rtl/level_controller.sv | 177 +++++++++++++++++
 tb/tb_level_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/level_controller_pkg.sv
// Shared game definitions: state encoding, level width and default timing constants.
// The round logic imports the same timing defaults so both blocks agree on durations.
package level_controller_pkg;

    localparam int unsigned LEVEL_W = 7;

    localparam int unsigned DEF_MAX_LEVEL      = 99;
    localparam int unsigned DEF_LEVEL_UP_CLKS  = 12_500_000;
    localparam int unsigned DEF_GAME_OVER_CLKS = 75_000_000;
    localparam int unsigned DEF_BLINK_CLKS     = 6_250_000;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlaying  = 3'd1,
        StLevelUp  = 3'd2,
        StGameOver = 3'd3,
        StWon      = 3'd4
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/level_controller_tick_timer.sv
// Loadable down-counter; expire_o is high while enabled and the count has reached zero.
module tick_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Independent of load_i so the parent can reload on expiry without a combinational loop.
    assign expire_o = en_i && (count_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/level_controller.sv
// Game progression: owns the current level, sequences start / level-up pause / game-over
// blink / final-win hold, and tracks the best level reached since reset.
module level_controller
    import level_controller_pkg::*;
#(
    parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int unsigned LEVEL_UP_CLKS  = DEF_LEVEL_UP_CLKS,
    parameter int unsigned GAME_OVER_CLKS = DEF_GAME_OVER_CLKS,
    parameter int unsigned BLINK_CLKS     = DEF_BLINK_CLKS
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    input  logic               i_Round_Win,
    input  logic               i_Round_Fail,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [LEVEL_W-1:0] o_Best,
    output logic               o_Blank,
    output logic               o_Playing,
    output logic               o_Level_Up,
    output logic               o_Round_Go
);

    localparam int unsigned MaxClks = max_u(max_u(LEVEL_UP_CLKS, GAME_OVER_CLKS), BLINK_CLKS);
    localparam int unsigned TimerW  = max_u($clog2(MaxClks), 1);

    // Timers count load..0 inclusive, so each dwell loads its length minus one.
    localparam logic [TimerW-1:0]  LuLoad = TimerW'(LEVEL_UP_CLKS - 1);
    localparam logic [TimerW-1:0]  GoLoad = TimerW'(GAME_OVER_CLKS - 1);
    localparam logic [TimerW-1:0]  BlLoad = TimerW'(BLINK_CLKS - 1);
    localparam logic [LEVEL_W-1:0] MaxLvl = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] Lvl1   = LEVEL_W'(1);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] best_q, best_d;
    logic               blank_q, blank_d;
    logic               playing_q, playing_d;
    logic               level_up_q, level_up_d;
    logic               round_go_q, round_go_d;

    logic               dwell_load, dwell_en, dwell_expire;
    logic [TimerW-1:0]  dwell_val;
    logic               blink_load, blink_en, blink_expire;

    tick_timer #(.Width(TimerW)) u_dwell_timer (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_L),
        .load_i     (dwell_load),
        .load_val_i (dwell_val),
        .en_i       (dwell_en),
        .expire_o   (dwell_expire)
    );

    tick_timer #(.Width(TimerW)) u_blink_timer (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_L),
        .load_i     (blink_load),
        .load_val_i (BlLoad),
        .en_i       (blink_en),
        .expire_o   (blink_expire)
    );

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        best_d     = best_q;
        blank_d    = blank_q;
        level_up_d = 1'b0;
        round_go_d = 1'b0;
        dwell_load = 1'b0;
        dwell_val  = '0;
        dwell_en   = 1'b0;
        blink_load = 1'b0;
        blink_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                level_d = '0;
                blank_d = 1'b0;
                if (i_Start) begin
                    state_d    = StPlaying;
                    level_d    = Lvl1;
                    round_go_d = 1'b1;
                end
            end
            StPlaying: begin
                if (i_Round_Fail) begin
                    state_d    = StGameOver;
                    blank_d    = 1'b1;
                    dwell_load = 1'b1;
                    dwell_val  = GoLoad;
                    blink_load = 1'b1;
                end else if (i_Round_Win) begin
                    if (level_q < MaxLvl) begin
                        state_d    = StLevelUp;
                        level_d    = level_q + 1'b1;
                        level_up_d = 1'b1;
                        dwell_load = 1'b1;
                        dwell_val  = LuLoad;
                    end else begin
                        state_d    = StWon;
                        blank_d    = 1'b1;
                        blink_load = 1'b1;
                    end
                end
            end
            StLevelUp: begin
                dwell_en = 1'b1;
                if (dwell_expire) begin
                    state_d    = StPlaying;
                    round_go_d = 1'b1;
                end
            end
            StGameOver: begin
                dwell_en = 1'b1;
                blink_en = 1'b1;
                if (blink_expire) begin
                    blank_d    = ~blank_q;
                    blink_load = 1'b1;
                end
                if (dwell_expire) begin
                    state_d = StIdle;
                    level_d = '0;
                    blank_d = 1'b0;
                end
            end
            StWon: begin
                blink_en = 1'b1;
                if (blink_expire) begin
                    blank_d    = ~blank_q;
                    blink_load = 1'b1;
                end
                if (i_Start) begin
                    state_d    = StPlaying;
                    level_d    = Lvl1;
                    blank_d    = 1'b0;
                    round_go_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (level_d > best_q) begin
            best_d = level_d;
        end
        playing_d = (state_d == StPlaying);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= StIdle;
            level_q    <= '0;
            best_q     <= '0;
            blank_q    <= 1'b0;
            playing_q  <= 1'b0;
            level_up_q <= 1'b0;
            round_go_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            best_q     <= best_d;
            blank_q    <= blank_d;
            playing_q  <= playing_d;
            level_up_q <= level_up_d;
            round_go_q <= round_go_d;
        end
    end

    assign o_Level    = level_q;
    assign o_Best     = best_q;
    assign o_Blank    = blank_q;
    assign o_Playing  = playing_q;
    assign o_Level_Up = level_up_q;
    assign o_Round_Go = round_go_q;

endmodule

// File: tb/tb_level_controller.sv
// Directed plus randomized bench for level_controller against a cycle-age reference model.
module tb_level_controller;

    localparam int unsigned MaxLevel = 3;
    localparam int unsigned LuClks   = 4;
    localparam int unsigned GoClks   = 16;
    localparam int unsigned BlClks   = 2;

    localparam int ModeIdle = 0, ModePlay = 1, ModeLvlUp = 2, ModeOver = 3, ModeWon = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, win = 1'b0, fail = 1'b0;
    logic [6:0] level, best;
    logic       blank, playing, level_up, round_go;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode, level, best, and cycles spent in the current mode.
    int m_mode, m_level, m_best, m_age, m_lu, m_go;

    level_controller #(
        .MAX_LEVEL      (MaxLevel),
        .LEVEL_UP_CLKS  (LuClks),
        .GAME_OVER_CLKS (GoClks),
        .BLINK_CLKS     (BlClks)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Start      (start),
        .i_Round_Win  (win),
        .i_Round_Fail (fail),
        .o_Level      (level),
        .o_Best       (best),
        .o_Blank      (blank),
        .o_Playing    (playing),
        .o_Level_Up   (level_up),
        .o_Round_Go   (round_go)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = ModeIdle; m_level = 0; m_best = 0; m_age = 0; m_lu = 0; m_go = 0;
    endtask

    task automatic enter(input int mode);
        m_mode = mode;
        m_age  = 0;
    endtask

    task automatic model_edge(input logic s, input logic w, input logic f);
        m_lu = 0;
        m_go = 0;
        case (m_mode)
            ModeIdle: if (s) begin enter(ModePlay); m_level = 1; m_go = 1; end
            ModePlay: begin
                if (f) enter(ModeOver);
                else if (w && m_level < int'(MaxLevel)) begin
                    m_level++; m_lu = 1; enter(ModeLvlUp);
                end else if (w) enter(ModeWon);
            end
            ModeLvlUp: begin
                if (m_age + 1 == int'(LuClks)) begin enter(ModePlay); m_go = 1; end
                else m_age++;
            end
            ModeOver: begin
                if (m_age + 1 == int'(GoClks)) begin enter(ModeIdle); m_level = 0; end
                else m_age++;
            end
            ModeWon: begin
                if (s) begin enter(ModePlay); m_level = 1; m_go = 1; end
                else m_age++;
            end
            default: ;
        endcase
        if (m_level > m_best) m_best = m_level;
    endtask

    function automatic int exp_blank();
        if (m_mode == ModeOver || m_mode == ModeWon) return ((m_age / BlClks) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        check("level",    32'(level),    m_level);
        check("best",     32'(best),     m_best);
        check("blank",    32'(blank),    exp_blank());
        check("playing",  32'(playing),  (m_mode == ModePlay) ? 1 : 0);
        check("level_up", 32'(level_up), m_lu);
        check("round_go", 32'(round_go), m_go);
    endtask

    task automatic step(input logic s, input logic w, input logic f);
        start = s; win = w; fail = f;
        @(posedge clk);
        model_edge(s, w, f);
        #1;
        start = 1'b0; win = 1'b0; fail = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        step(1, 0, 0);                                  // start: level 1, go, best 1
        step(0, 0, 0);
        step(0, 1, 0);                                  // win -> level 2, level-up pause
        step(1, 1, 0);                                  // ignored during LEVEL_UP
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);                                  // back in PLAYING with go
        step(0, 1, 1);                                  // fail wins priority
        for (int i = 0; i < 18; i++) step(i % 3 == 0, i % 2 == 0, 0);

        step(1, 0, 0);                                  // new game, climb to WON
        for (int lv = 0; lv < 2; lv++) begin
            step(0, 1, 0);
            for (int i = 0; i < 5; i++) step(0, 0, 0);
        end
        step(0, 1, 0);                                  // at max level -> WON
        for (int i = 0; i < 7; i++) step(0, 1, 0);
        step(1, 0, 0);                                  // restart from WON

        step(0, 0, 1);                                  // into GAME_OVER, then async reset
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
        check_all();
        step(1, 0, 0);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
